// File: rtl/gif_frame_sequencer.sv
// gif_frame_sequencer
// Purpose: sits between the panel scan controller and the four-frame GIF
//   pixel memory. Forwards scanner pixel reads to the memory with a fixed
//   two-cycle request-to-data latency. Drives the memory frame select, and
//   changes it only on the cycle after a refresh boundary. A frame is shown
//   for a programmable number of refreshes, or stepped by hand while paused.
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_play                        1 = auto-advance, 0 = paused
//   i_step                        one-cycle pulse, single-frame advance while paused
//   i_hold_cfg[HOLD_W]            refreshes per frame (0 treated as 1)
//   i_refresh_done                end-of-refresh pulse from the scanner
//   i_rd_req, i_rd_addr[WIDTH]    scanner read request / address
//   o_mem_rd, o_mem_address       read strobe / address to memory
//   o_mem_frame_sel[2]            frame select to memory
//   o_rd_valid                    memory read data valid for the scanner
//   o_cur_frame[2]                displayed frame (same as o_mem_frame_sel)
//   o_frame_tick                  one-cycle pulse on every frame advance
// Build option: define GIF_PINGPONG_EN for the bounce order 0,1,..,N-1,..,1,0.
//   When it is undefined the order wraps: 0,1,..,N-1,0.
module gif_frame_sequencer #(
    parameter int WIDTH      = 11,
    parameter int NUM_FRAMES = 4,
    parameter int HOLD_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_play,
    input  logic              i_step,
    input  logic [HOLD_W-1:0] i_hold_cfg,
    input  logic              i_refresh_done,
    input  logic              i_rd_req,
    input  logic [WIDTH-1:0]  i_rd_addr,
    output logic              o_mem_rd,
    output logic [WIDTH-1:0]  o_mem_address,
    output logic [1:0]        o_mem_frame_sel,
    output logic              o_rd_valid,
    output logic [1:0]        o_cur_frame,
    output logic              o_frame_tick
);

    typedef enum logic [0:0] {
        ST_PAUSED  = 1'b0,
        ST_PLAYING = 1'b1
    } state_t;

    localparam logic [1:0]        LP_LAST = 2'(NUM_FRAMES - 1);
    localparam logic [HOLD_W-1:0] LP_ONE  = HOLD_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_frame;
    logic [1:0]        w_frame_nxt;
    logic              r_tick;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [HOLD_W-1:0] w_hold_eff;
    logic              r_step_pend;
    logic              w_step_nxt;
    logic              w_advance;

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_PAUSED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: play level is sampled every cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_PAUSED: begin
                if (i_play) w_state_nxt = ST_PLAYING;
                else        w_state_nxt = ST_PAUSED;
            end
            ST_PLAYING: begin
                if (i_play) w_state_nxt = ST_PLAYING;
                else        w_state_nxt = ST_PAUSED;
            end
            default: w_state_nxt = ST_PAUSED;
        endcase
    end

    assign w_hold_eff = (i_hold_cfg == '0) ? LP_ONE : i_hold_cfg;

    // FSM outputs: advance decision, hold counter and step-pending updates.
    // A refresh on the cycle play changes is still handled by the old state.
    always_comb begin
        w_advance  = 1'b0;
        w_hold_nxt = r_hold_cnt;
        w_step_nxt = r_step_pend;
        case (r_state)
            ST_PLAYING: begin
                w_step_nxt = 1'b0;
                if (i_refresh_done) begin
                    if (r_hold_cnt >= (w_hold_eff - LP_ONE)) begin
                        w_advance  = 1'b1;
                        w_hold_nxt = '0;
                    end else if (r_hold_cnt != '1) begin
                        w_hold_nxt = r_hold_cnt + LP_ONE;
                    end else begin
                        w_hold_nxt = r_hold_cnt;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt;
                end
                // leaving for PAUSED restarts the hold count from zero
                if (!i_play) begin
                    w_hold_nxt = '0;
                end else begin
                    w_hold_nxt = w_hold_nxt;
                end
            end
            ST_PAUSED: begin
                w_hold_nxt = '0;
                // several steps before a refresh collapse into one advance
                if (i_refresh_done && (r_step_pend || i_step)) begin
                    w_advance  = 1'b1;
                    w_step_nxt = 1'b0;
                end else if (i_step) begin
                    w_step_nxt = 1'b1;
                end else begin
                    w_step_nxt = r_step_pend;
                end
            end
            default: begin
                w_advance  = 1'b0;
                w_hold_nxt = '0;
                w_step_nxt = 1'b0;
            end
        endcase
    end

`ifdef GIF_PINGPONG_EN
    logic r_dir_up;
    logic w_dir_nxt;

    // Bounce order: direction flips whenever an end frame is reached
    always_comb begin
        if (NUM_FRAMES == 1) begin
            w_frame_nxt = 2'd0;
        end else if (r_dir_up) begin
            w_frame_nxt = r_frame + 2'd1;
        end else begin
            w_frame_nxt = r_frame - 2'd1;
        end
        if (w_frame_nxt == LP_LAST) begin
            w_dir_nxt = 1'b0;
        end else if (w_frame_nxt == 2'd0) begin
            w_dir_nxt = 1'b1;
        end else begin
            w_dir_nxt = r_dir_up;
        end
    end

    // Direction register, updated only on a frame advance
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dir_up <= 1'b1;
        end else if (w_advance) begin
            r_dir_up <= w_dir_nxt;
        end else begin
            r_dir_up <= r_dir_up;
        end
    end
`else
    // Wrap order: last frame returns to frame 0
    always_comb begin
        if (r_frame == LP_LAST) begin
            w_frame_nxt = 2'd0;
        end else begin
            w_frame_nxt = r_frame + 2'd1;
        end
    end
`endif

    // Frame, tick, hold counter and step-pending registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame     <= 2'd0;
            r_tick      <= 1'b0;
            r_hold_cnt  <= '0;
            r_step_pend <= 1'b0;
        end else begin
            r_frame     <= w_advance ? w_frame_nxt : r_frame;
            r_tick      <= w_advance;
            r_hold_cnt  <= w_hold_nxt;
            r_step_pend <= w_step_nxt;
        end
    end

    // Read pipeline; reset drops anything in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_mem_rd      <= 1'b0;
            o_mem_address <= '0;
            o_rd_valid    <= 1'b0;
        end else begin
            o_mem_rd      <= i_rd_req;
            o_mem_address <= i_rd_addr;
            o_rd_valid    <= o_mem_rd;
        end
    end

    assign o_mem_frame_sel = r_frame;
    assign o_cur_frame     = r_frame;
    assign o_frame_tick    = r_tick;

endmodule

// File: tb/tb_gif_frame_sequencer.sv
// Testbench for gif_frame_sequencer: table of per-cycle vectors for the frame
// sequencing, a queue scoreboard for the read path, and hand-written
// sequences for asynchronous reset and the bounce order build option.
module tb_gif_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        play, step, refresh_done, rd_req;
    logic [7:0]  hold_cfg;
    logic [10:0] rd_addr;
    logic        mem_rd, rd_valid, frame_tick;
    logic [10:0] mem_address;
    logic [1:0]  mem_frame_sel, cur_frame;

    always #5 clk = ~clk;

    gif_frame_sequencer #(.WIDTH(11), .NUM_FRAMES(4), .HOLD_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_play(play), .i_step(step),
        .i_hold_cfg(hold_cfg), .i_refresh_done(refresh_done),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr),
        .o_mem_rd(mem_rd), .o_mem_address(mem_address),
        .o_mem_frame_sel(mem_frame_sel), .o_rd_valid(rd_valid),
        .o_cur_frame(cur_frame), .o_frame_tick(frame_tick)
    );

    typedef struct {
        logic        play;
        logic        step;
        logic        refr;
        logic [7:0]  hold;
        logic        rq;
        logic [10:0] addr;
        logic        exp_tick;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [10:0] addr;
    } rd_exp_t;

    vec_t    vecs[$];
    rd_exp_t q_rd[$];
    int      q_v[$];
    int      n_checks = 0;
    int      n_errors = 0;
    int      cyc = 0;
    int      m_frame = 0;
    bit      m_dir_up = 1'b1;
    int      pp_exp[8] = '{1, 2, 3, 2, 1, 0, 1, 2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference frame order, written independently of the design
    task automatic model_advance();
`ifdef GIF_PINGPONG_EN
        if (m_dir_up) m_frame = m_frame + 1;
        else          m_frame = m_frame - 1;
        if (m_frame == 3)      m_dir_up = 1'b0;
        else if (m_frame == 0) m_dir_up = 1'b1;
`else
        m_frame = (m_frame == 3) ? 0 : m_frame + 1;
`endif
    endtask

    // Compare read strobe / valid against the scoreboard queues
    task automatic sb_check();
        logic    exp_rd, exp_v;
        rd_exp_t e;
        while (q_rd.size() > 0 && q_rd[0].cyc < cyc) void'(q_rd.pop_front());
        while (q_v.size() > 0 && q_v[0] < cyc) void'(q_v.pop_front());
        exp_rd = (q_rd.size() > 0) && (q_rd[0].cyc == cyc);
        exp_v  = (q_v.size() > 0) && (q_v[0] == cyc);
        chk("mem_rd", 32'(mem_rd), 32'(exp_rd));
        if (exp_rd) begin
            e = q_rd.pop_front();
            chk("mem_address", 32'(mem_address), 32'(e.addr));
        end
        chk("rd_valid", 32'(rd_valid), 32'(exp_v));
        if (exp_v) void'(q_v.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        sb_check();
    endtask

    task automatic add(input logic p, input logic s, input logic r, input logic [7:0] h,
                       input logic rq, input logic [10:0] a, input logic t);
        vec_t v;
        v.play = p; v.step = s; v.refr = r; v.hold = h;
        v.rq = rq; v.addr = a; v.exp_tick = t;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, then check frame outputs after the edge
    task automatic drive(input logic p, input logic s, input logic r, input logic [7:0] h,
                         input logic rq, input logic [10:0] a, input logic t);
        rd_exp_t e;
        play = p; step = s; refresh_done = r; hold_cfg = h;
        rd_req = rq; rd_addr = a;
        if (rq) begin
            e.cyc = cyc + 1;
            e.addr = a;
            q_rd.push_back(e);
            q_v.push_back(cyc + 2);
        end
        tick();
        if (t) model_advance();
        chk("frame_tick", 32'(frame_tick), 32'(t));
        chk("cur_frame", 32'(cur_frame), 32'(m_frame));
        chk("mem_frame_sel", 32'(mem_frame_sel), 32'(m_frame));
    endtask

    initial begin
        rst = 1'b1; play = 1'b0; step = 1'b0; refresh_done = 1'b0;
        hold_cfg = 8'd0; rd_req = 1'b0; rd_addr = 11'd0;

        // read latency while paused at frame 0
        add(1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 11'h005, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 11'h000, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 11'h000, 1'b0);
        // hold 3, twelve refreshes: advance after 3, 6, 9, 12; step ignored while playing
        add(1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 11'h000, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            add(1'b1, (k == 5) ? 1'b1 : 1'b0, 1'b1, 8'd3, (k % 4) == 1,
                11'(k * 171), (k % 3) == 0);
        end
        add(1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 11'h7FF, 1'b0);
        // hold 0 behaves as hold 1
        add(1'b1, 1'b0, 1'b1, 8'd0, 1'b1, 11'h000, 1'b1);
        add(1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 11'h000, 1'b1);
        add(1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 11'h000, 1'b1);
        add(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 11'h000, 1'b0);
        // paused: two steps collapse to one advance; refresh alone does nothing;
        // step and refresh on the same cycle advance
        add(1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 11'h000, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 11'h000, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 11'h000, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 11'h000, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 11'h000, 1'b1);
        add(1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 11'h000, 1'b0);
        add(1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 11'h123, 1'b1);
        add(1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 11'h456, 1'b0);
        // pause mid-hold clears the hold count
        add(1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 11'h000, 1'b0);
        add(1'b1, 1'b0, 1'b1, 8'd4, 1'b0, 11'h000, 1'b0);
        add(1'b1, 1'b0, 1'b1, 8'd4, 1'b0, 11'h000, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 11'h000, 1'b0);
        add(1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 11'h000, 1'b0);
        add(1'b1, 1'b0, 1'b1, 8'd4, 1'b0, 11'h000, 1'b0);
        add(1'b1, 1'b0, 1'b1, 8'd4, 1'b0, 11'h000, 1'b0);
        add(1'b1, 1'b0, 1'b1, 8'd4, 1'b0, 11'h000, 1'b0);
        add(1'b1, 1'b0, 1'b1, 8'd4, 1'b0, 11'h000, 1'b1);
        add(1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 11'h000, 1'b0);
        // refresh on the cycle play drops is still handled as playing
        add(1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 11'h000, 1'b1);
        add(1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 11'h000, 1'b0);

        // reset values
        @(posedge clk);
        #1;
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_frame_sel", 32'(mem_frame_sel), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_cur_frame", 32'(cur_frame), 32'd0);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].play, vecs[i].step, vecs[i].refr, vecs[i].hold,
                  vecs[i].rq, vecs[i].addr, vecs[i].exp_tick);
        end

        // reset mid-play at frame 2 with a read in flight
        drive(1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 11'h000, 1'b0);
        for (int i = 0; i < 8 && m_frame != 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 11'h000, 1'b1);
        end
        chk("pre_reset_frame", 32'(cur_frame), 32'd2);
        drive(1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 11'h2AA, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_mem_rd", 32'(mem_rd), 32'd0);
        chk("async_mem_address", 32'(mem_address), 32'd0);
        chk("async_mem_frame_sel", 32'(mem_frame_sel), 32'd0);
        chk("async_rd_valid", 32'(rd_valid), 32'd0);
        chk("async_cur_frame", 32'(cur_frame), 32'd0);
        chk("async_frame_tick", 32'(frame_tick), 32'd0);
        q_rd.delete();
        q_v.delete();
        m_frame = 0;
        m_dir_up = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 11'h000, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 11'h000, 1'b0);

`ifdef GIF_PINGPONG_EN
        drive(1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 11'h000, 1'b0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 11'h000, 1'b1);
            chk("pingpong_frame", 32'(cur_frame), 32'(pp_exp[k]));
        end
`endif

        drive(1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 11'h000, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 11'h000, 1'b0);
        chk("rd_queue_drained", 32'(q_rd.size()), 32'd0);
        chk("valid_queue_drained", 32'(q_v.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gif_frame_sequencer.md
# gif_frame_sequencer

Controller for the four-frame GIF pixel memory. It forwards pixel read requests from the display scanner to the memory and drives the memory's frame select. It advances the animation frame only at display refresh boundaries, after a programmable number of refreshes, so no refresh ever shows pixels from two frames. It sits between the panel scan controller and `memory_gif`.

## Interface
- `WIDTH`, 11: pixel address width; matches the memory address port.
- `NUM_FRAMES`, 4: frames in memory; legal range 1..4.
- `HOLD_W`, 8: width of the hold-count configuration.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `play` in 1: level; 1 = auto-advance frames, 0 = paused.
- `step` in 1: one-cycle pulse; while paused, requests a one-frame advance.
- `hold_cfg` in HOLD_W: number of refreshes each frame is shown; 0 is treated as 1.
- `refresh_done` in 1: one-cycle pulse from the scanner at the end of a full panel refresh.
- `rd_req` in 1: scanner requests a pixel-pair read this cycle.
- `rd_addr` in WIDTH: address for `rd_req`.
- `mem_rd` out 1: read strobe to memory.
- `mem_address` out WIDTH: address to memory.
- `mem_frame_sel` out 2: frame select to memory.
- `rd_valid` out 1: memory `rdata` is valid this cycle for the scanner.
- `cur_frame` out 2: frame currently displayed; equals `mem_frame_sel`.
- `frame_tick` out 1: one-cycle pulse on every frame change.

## Operation
- Read path, no backpressure:
  - `mem_rd` <= `rd_req`; `mem_address` <= `rd_addr`; `rd_valid` <= `mem_rd`.
  - Every request yields exactly one `rd_valid`, in order.
- FSM states: PAUSED (reset state) and PLAYING.
  - PAUSED -> PLAYING on `play`=1; PLAYING -> PAUSED on `play`=0. Both are evaluated every cycle.
  - Entering PAUSED clears `hold_cnt` and clears `step_pend`.
- PLAYING, on each `refresh_done`:
  - `hold_eff` = max(`hold_cfg`, 1), sampled on that cycle.
  - If `hold_cnt` >= `hold_eff` - 1: advance the frame, set `hold_cnt` to 0, pulse `frame_tick`.
  - Otherwise: increment `hold_cnt` (HOLD_W bits, saturating).
- PAUSED:
  - `step` sets `step_pend`.
  - The next `refresh_done` with `step_pend` (or with a `step` on that same cycle) advances the frame, clears `step_pend` and pulses `frame_tick`.
  - Multiple steps before a refresh collapse into one advance.
  - `refresh_done` without a pending step has no effect.
- Frame advance order, default: 0, 1, …, NUM_FRAMES-1, 0 (wrap).
- `NUM_FRAMES`=1: frame stays 0. `frame_tick` still pulses on each advance event.
- `mem_frame_sel` changes only on the cycle after `refresh_done`. It is never changed mid-refresh.
- Reads in flight across a frame change return the old frame's data if issued before the change.

## Timing
- Request to data: `rd_req` at cycle N -> `mem_rd` at N+1 -> `rd_valid` with `rdata` at N+2.
- `refresh_done` at cycle N -> new `mem_frame_sel`/`cur_frame` and `frame_tick`=1 at N+1.
- `play` change at N -> state change at N+1. A `refresh_done` at N is handled under the old state.
- Reset values: `mem_rd`=0, `mem_address`=0, `mem_frame_sel`=0, `rd_valid`=0, `cur_frame`=0, `frame_tick`=0.
- Reset values, internal: `hold_cnt`=0, `step_pend`=0, direction=up, state=PAUSED.
- Reset asserted mid-operation drops any in-flight read: no `rd_valid` is issued after reset.

## Configuration
- `GIF_PINGPONG_EN` defined: playback bounces between the end frames.
  - Sequence 0,1,2,3,2,1,0,1… for NUM_FRAMES=4.
  - A direction register flips on reaching frame 0 or frame NUM_FRAMES-1.
  - NUM_FRAMES=2 gives 0,1,0,1.
- `GIF_PINGPONG_EN` undefined: wrap order only; no direction register.

## Test plan
- Read latency: reset, `rd_req`=1 with `rd_addr`=0x005 for 1 cycle -> `mem_rd`=1 and `mem_address`=0x005 at +1; `rd_valid`=1 at +2 only.
- Hold count: `play`=1, `hold_cfg`=3, 12 `refresh_done` pulses -> `cur_frame` 0→1→2→3→0, changing after pulses 3, 6, 9, 12; 4 `frame_tick` pulses.
- Hold zero: `hold_cfg`=0, `play`=1 -> frame advances on every `refresh_done`.
- Step while paused: `play`=0, two `step` pulses, then one `refresh_done` -> exactly one advance (0→1). `step` and `refresh_done` on the same cycle -> advance.
- Pause mid-hold: `hold_cfg`=4; 2 refreshes; `play`=0; `play`=1; 3 refreshes -> no advance. 4th refresh -> advance, because `hold_cnt` was cleared on pause.
- Reset mid-play: `rst` pulse during `cur_frame`=2 with a read in flight -> all outputs 0 asynchronously, no `rd_valid`. With `GIF_PINGPONG_EN`: 8 refreshes at hold 1 -> frames 1,2,3,2,1,0,1,2.
